fetch_unit: RTL and testbench

Instruction fetch stage of the processor: owns the program counter, issues word reads to instruction memory over a request/grant/response interface, and presents one fetched instruction at a time, with its PC, to the decoder through a valid/ready handshake. It accepts PC redirects from branch/jump resolution. Redirects discard any stale in-flight or buffered instruction.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and constants
// Purpose: FSM state encoding for the fetch stage and the NOP word that the
//          decoder sees whenever no fetched instruction is held.
// Ports:   none (package).
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry instruction buffer
// Purpose: owns the PC, issues single outstanding word reads to instruction
//          memory and hands one instruction at a time to the decoder.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr (out)        read request, address = current PC
//   imem_gnt (in)              request accepted
//   imem_rvalid/rdata (in)     read response
//   redirect_valid/pc (in)     new PC from branch/jump resolution
//   instr_valid (out)          instruction/instr_pc hold a fetched word
//   instr_ready (in)           decoder consumes the instruction
//   instruction/instr_pc (out) fetched word and its address
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_drop, w_drop_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic [31:0]  r_instr_pc, w_instr_pc_nxt;
  logic [31:0]  w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC & ALIGN_MASK;
      r_drop     <= 1'b0;
      r_buf      <= NOP_INSTR;
      r_instr_pc <= RESET_PC & ALIGN_MASK;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_buf      <= w_buf_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_buf_nxt      = r_buf;
    w_instr_pc_nxt = r_instr_pc;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        // An ungranted request simply retargets; a granted one that is
        // redirected in the same cycle must have its response discarded.
        if (redirect_valid) w_pc_nxt = w_redirect_pc;
        if (imem_gnt) begin
          w_state_nxt = WAIT;
          w_drop_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (r_drop || redirect_valid) begin
            w_state_nxt = REQ;
            w_drop_nxt  = 1'b0;
            if (redirect_valid) w_pc_nxt = w_redirect_pc;
          end else begin
            w_state_nxt    = HOLD;
            w_buf_nxt      = imem_rdata;
            w_instr_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + 32'd4;
          end
        end else if (redirect_valid) begin
          // Response still owed for the old PC: wait for it, then drop it.
          w_pc_nxt   = w_redirect_pc;
          w_drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        // Redirect takes priority over a same-cycle handshake.
        if (redirect_valid) begin
          w_state_nxt = REQ;
          w_pc_nxt    = w_redirect_pc;
        end else if (instr_ready) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == HOLD);
  assign instruction = instr_valid ? r_buf : NOP_INSTR;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: grant now, respond on the next cycle.
  task automatic fetch_word(input logic [31:0] data, input logic [31:0] pc, input bit deliver);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (deliver) exp_q.push_back({pc, data});
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, imem_addr, instruction, instr_pc} !== {2'b00, 32'h0, NOP_INSTR, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_async: got req=%b valid=%b addr=%h instr=%h pc=%h, expected 0 0 0 %h 0",
               imem_req, instr_valid, imem_addr, instruction, instr_pc, NOP_INSTR);
    end
    tick();
    tick();
    n_checks++;
    if ({imem_req, instr_valid, imem_addr, instruction} !== {2'b00, 32'h0, NOP_INSTR}) begin
      n_errors++;
      $display("FAIL reset_held: got req=%b valid=%b addr=%h instr=%h, expected 0 0 0 %h",
               imem_req, instr_valid, imem_addr, instruction, NOP_INSTR);
    end
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    tick();  // edge 0
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL basic_edge0: got req=%b valid=%b addr=%h, expected 1 0 00000000", imem_req, instr_valid, imem_addr);
    end
    imem_gnt = 1'b1;
    tick();  // edge 1
    imem_gnt = 1'b0;
    n_checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_edge1: got req=%b valid=%b, expected 0 0", imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    exp_q.push_back({32'h0, 32'h0000_0013});
    tick();  // edge 2
    imem_rvalid = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL basic_first: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL basic_first: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
    tick();
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h4}) begin
      n_errors++;
      $display("FAIL basic_addr2: got req=%b valid=%b addr=%h, expected 1 0 00000004", imem_req, instr_valid, imem_addr);
    end
    fetch_word(32'h0020_8133, 32'h4, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL basic_second: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL basic_second: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    tick();  // handshake, back to REQ at 0x8
    instr_ready = 1'b0;
    fetch_word(32'hABCD_0001, 32'h8, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL stall_data: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL stall_data: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({instr_valid, imem_req, instr_pc, instruction} !== {2'b10, 32'h8, 32'hABCD_0001}) begin
        n_errors++;
        $display("FAIL stall_hold%0d: got valid=%b req=%b pc=%h instr=%h, expected 1 0 00000008 abcd0001",
                 i, instr_valid, imem_req, instr_pc, instruction);
      end
    end
    instr_ready = 1'b1;
    tick();
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'hC}) begin
      n_errors++;
      $display("FAIL stall_next: got req=%b valid=%b addr=%h, expected 1 0 0000000c", imem_req, instr_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();  // WAIT for 0xC
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();  // still WAIT, response now stale
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h100}) begin
      n_errors++;
      $display("FAIL redir_wait_drop: got req=%b valid=%b addr=%h, expected 1 0 00000100", imem_req, instr_valid, imem_addr);
    end
    fetch_word(32'h0000_0093, 32'h100, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL redir_wait_target: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL redir_wait_target: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_redirect_hold();
    redirect_valid = 1'b1;  // instr_ready is also 1 in this cycle
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({instr_valid, imem_req, instruction, imem_addr} !== {2'b01, NOP_INSTR, 32'h200}) begin
      n_errors++;
      $display("FAIL redir_hold: got valid=%b req=%b instr=%h addr=%h, expected 0 1 %h 00000200",
               instr_valid, imem_req, instruction, imem_addr, NOP_INSTR);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;  // retarget an ungranted request
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_errors++;
      $display("FAIL wrap_target: got req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
    end
    fetch_word(32'h4444_4444, 32'hFFFF_FFFC, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL wrap_data: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL wrap_data: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
    tick();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL wrap_next: got req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    tick();  // WAIT for 0x40
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, imem_addr, instruction, instr_pc} !== {2'b00, 32'h0, NOP_INSTR, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_mid: got req=%b valid=%b addr=%h instr=%h pc=%h, expected 0 0 0 %h 0",
               imem_req, instr_valid, imem_addr, instruction, instr_pc, NOP_INSTR);
    end
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;  // stray response to the pre-reset request
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_stray_idle: got req=%b valid=%b addr=%h, expected 1 0 00000000", imem_req, instr_valid, imem_addr);
    end
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_stray_req: got req=%b valid=%b addr=%h, expected 1 0 00000000", imem_req, instr_valid, imem_addr);
    end
    fetch_word(32'h5555_5555, 32'h0, 1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL reset_refetch: scoreboard empty, valid=%b", instr_valid);
    end else begin
      exp = exp_q.pop_front();
      if ({instr_valid, instr_pc, instruction} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL reset_refetch: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 instr_valid, instr_pc, instruction, exp[63:32], exp[31:0]);
      end
    end
    tick();
    n_checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h4}) begin
      n_errors++;
      $display("FAIL reset_next: got req=%b valid=%b addr=%h, expected 1 0 00000004", imem_req, instr_valid, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
